tt_uio_bus_arbiter: RTL and testbench

- Time-shares the 8-bit bidirectional uio pad bus between two on-die requesters (e.g. a pattern generator and a readback probe) inside a TinyTapeout tile.
- Grants exclusive tenures using round-robin arbitration.
- Sets pad direction per tenure and inserts a guaranteed high-Z turnaround between tenures.
- Registers both the pad outputs and the captured pad inputs.

---
 rtl/tt_uio_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_tt_uio_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tt_uio_bus_arbiter
// Description : Round-robin time-sharing of the 8-bit bidirectional uio pad
//               bus between two requesters. Each tenure has a fixed pad
//               direction. Every hand-over is preceded by a high-Z turnaround.
//               Pad outputs and captured pad inputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_uio_bus_arbiter #(
  parameter int MAX_HOLD    = 16,  // beats per tenure before forced release (2..255)
  parameter int TURN_CYCLES = 1    // high-Z cycles between tenures (1..15)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] req,
  input  logic [1:0] req_dir,
  input  logic [1:0] req_last,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic       rd_valid,
  output logic       rd_id,
  output logic [7:0] rd_data,
  output logic       timeout,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_turn = 2'd1;
  localparam logic [1:0] c_st_own  = 2'd2;

  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
  localparam logic [3:0] c_turn_load = 4'(TURN_CYCLES - 1);

  logic [1:0] state_q,    state_d;
  logic       owner_q,    owner_d;
  logic       dir_q,      dir_d;
  logic       rr_ptr_q,   rr_ptr_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] gnt_q,      gnt_d;
  logic       timeout_q,  timeout_d;
  logic [7:0] uio_out_q,  uio_out_d;
  logic [7:0] uio_oe_q,   uio_oe_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_id_q,    rd_id_d;
  logic [7:0] rd_data_q,  rd_data_d;

  logic       w_pick;
  logic       w_other;
  logic       w_beat;
  logic       w_release;
  logic [7:0] w_wdata;

  // Arbitration helpers: IDLE pick favours rr_ptr, a beat is any OWN cycle
  // with the owner still requesting.
  always_comb begin
    w_pick  = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    w_other = ~owner_q;
    w_beat  = (state_q == c_st_own) && req[owner_q];
    w_wdata = owner_q ? wdata1 : wdata0;
  end

  // Tenure FSM: arbitration, turnaround countdown, beat counting and release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    dir_d      = dir_q;
    rr_ptr_d   = rr_ptr_q;
    turn_cnt_d = turn_cnt_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    timeout_d  = 1'b0;
    w_release  = 1'b0;

    case (state_q)
      c_st_idle: begin
        gnt_d = 2'b00;
        if (ena && (req != 2'b00)) begin
          owner_d    = w_pick;
          dir_d      = req_dir[w_pick];
          turn_cnt_d = c_turn_load;
          state_d    = c_st_turn;
        end
      end

      c_st_turn: begin
        gnt_d = 2'b00;
        if (turn_cnt_q == 4'd0) begin
          state_d    = c_st_own;
          gnt_d      = owner_q ? 2'b10 : 2'b01;
          hold_cnt_d = 8'd0;
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end

      c_st_own: begin
        // Dropped request beats req_last, which beats the hold limit.
        if (!req[owner_q]) begin
          w_release = 1'b1;
        end else if (req_last[owner_q]) begin
          w_release = 1'b1;
        end else if (hold_cnt_q == c_hold_last) begin
          w_release = 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end

        if (w_release) begin
          gnt_d    = 2'b00;
          rr_ptr_d = w_other;
          // A waiting peer skips IDLE so the bus never idles longer than the
          // mandatory turnaround.
          if (ena && req[w_other]) begin
            owner_d    = w_other;
            dir_d      = req_dir[w_other];
            turn_cnt_d = c_turn_load;
            state_d    = c_st_turn;
          end else begin
            state_d = c_st_idle;
          end
        end
      end

      default: begin
        state_d = c_st_idle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Pad and capture pipelines: drive only in the cycle after a drive beat,
  // capture only on a sample beat; captured data/id persist between pulses.
  always_comb begin
    uio_oe_d   = 8'h00;
    uio_out_d  = 8'h00;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    if (w_beat && dir_q) begin
      uio_oe_d  = 8'hFF;
      uio_out_d = w_wdata;
    end
    if (w_beat && !dir_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = uio_in;
      rd_id_d    = owner_q;
    end
  end

  // State registers with synchronous reset; reset releases the pads at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      owner_q    <= 1'b0;
      dir_q      <= 1'b0;
      rr_ptr_q   <= 1'b0;
      turn_cnt_q <= 4'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 2'b00;
      timeout_q  <= 1'b0;
      uio_out_q  <= 8'h00;
      uio_oe_q   <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      dir_q      <= dir_d;
      rr_ptr_q   <= rr_ptr_d;
      turn_cnt_q <= turn_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign timeout  = timeout_q;
  assign uio_out  = uio_out_q;
  assign uio_oe   = uio_oe_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_uio_bus_arbiter
// Description : Scoreboard bench for tt_uio_bus_arbiter. Two instances share
//               the stimulus: A (MAX_HOLD=4, TURN_CYCLES=1), B (MAX_HOLD=2,
//               TURN_CYCLES=3). A tenure-level reference model predicts every
//               cycle's outputs and every captured read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_uio_bus_arbiter;

  localparam int A_HOLD = 4;
  localparam int A_TURN = 1;
  localparam int B_HOLD = 2;
  localparam int B_TURN = 3;

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] oe;
    logic [7:0] out;
    logic       rd_valid;
    logic       timeout;
  } exp_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } rd_t;

  // Tenure view: who holds (or is waiting for) the bus, how many turnaround
  // cycles remain before the grant, and how many beats were already taken.
  typedef struct {
    bit busy;
    int owner;
    bit dir;
    int gap;
    int beats;
    int pref;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [1:0] req, req_dir, req_last;
  logic [7:0] wdata0, wdata1, uio_in;

  logic [1:0] gnt_a, gnt_b;
  logic       rd_valid_a, rd_valid_b, rd_id_a, rd_id_b, timeout_a, timeout_b;
  logic [7:0] rd_data_a, rd_data_b, uio_out_a, uio_out_b, uio_oe_a, uio_oe_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  rd_t  rdq_a[$];
  rd_t  rdq_b[$];
  mdl_t ma, mb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tt_uio_bus_arbiter #(.MAX_HOLD(A_HOLD), .TURN_CYCLES(A_TURN)) u_dut_a (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dir(req_dir),
    .req_last(req_last), .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_a),
    .rd_valid(rd_valid_a), .rd_id(rd_id_a), .rd_data(rd_data_a),
    .timeout(timeout_a), .uio_in(uio_in), .uio_out(uio_out_a), .uio_oe(uio_oe_a)
  );

  tt_uio_bus_arbiter #(.MAX_HOLD(B_HOLD), .TURN_CYCLES(B_TURN)) u_dut_b (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dir(req_dir),
    .req_last(req_last), .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_b),
    .rd_valid(rd_valid_b), .rd_id(rd_id_b), .rd_data(rd_data_b),
    .timeout(timeout_b), .uio_in(uio_in), .uio_out(uio_out_b), .uio_oe(uio_oe_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Predicts the outputs after the coming clock edge from the current inputs.
  function automatic void model_step(input mdl_t mi, input int max_hold, input int turn,
                                     output mdl_t mo, output exp_t e,
                                     output bit rv, output rd_t r);
    bit rel;
    mo = mi;
    e.gnt = 2'b00; e.oe = 8'h00; e.out = 8'h00; e.rd_valid = 1'b0; e.timeout = 1'b0;
    rv = 1'b0; r.id = 1'b0; r.data = 8'h00;
    rel = 1'b0;
    if (rst) begin
      mo.busy = 0; mo.owner = 0; mo.dir = 0; mo.gap = 0; mo.beats = 0; mo.pref = 0;
      return;
    end
    if (!mi.busy) begin
      if (ena && (req != 2'b00)) begin
        mo.owner = req[mi.pref] ? mi.pref : 1 - mi.pref;
        mo.busy  = 1;
        mo.dir   = req_dir[mo.owner];
        mo.gap   = turn;
      end
    end else if (mi.gap > 0) begin
      mo.gap = mi.gap - 1;
      if (mo.gap == 0) begin
        mo.beats = 0;
        e.gnt    = 2'b01 << mi.owner;
      end
    end else begin
      if (!req[mi.owner]) begin
        rel = 1'b1;
      end else begin
        if (mi.dir) begin
          e.oe  = 8'hFF;
          e.out = (mi.owner == 1) ? wdata1 : wdata0;
        end else begin
          e.rd_valid = 1'b1;
          rv = 1'b1; r.id = 1'(mi.owner); r.data = uio_in;
        end
        if (req_last[mi.owner]) rel = 1'b1;
        else if (mi.beats + 1 == max_hold) begin
          rel = 1'b1; e.timeout = 1'b1;
        end else mo.beats = mi.beats + 1;
      end
      if (rel) begin
        mo.pref = 1 - mi.owner;
        if (ena && req[1 - mi.owner]) begin
          mo.owner = 1 - mi.owner;
          mo.dir   = req_dir[mo.owner];
          mo.gap   = turn;
        end else begin
          mo.busy = 0;
        end
      end else begin
        e.gnt = 2'b01 << mi.owner;
      end
    end
  endfunction

  // Applies one cycle of inputs, records the predicted response, then waits.
  task automatic cyc(input logic r, input logic en, input logic [1:0] rq,
                     input logic [1:0] dr, input logic [1:0] ls,
                     input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] ui);
    mdl_t nxt;
    exp_t e;
    bit   rv;
    rd_t  rr;
    rst = r; ena = en; req = rq; req_dir = dr; req_last = ls;
    wdata0 = w0; wdata1 = w1; uio_in = ui;
    model_step(ma, A_HOLD, A_TURN, nxt, e, rv, rr);
    ma = nxt; exp_a.push_back(e);
    if (rv) rdq_a.push_back(rr);
    model_step(mb, B_HOLD, B_TURN, nxt, e, rv, rr);
    mb = nxt; exp_b.push_back(e);
    if (rv) rdq_b.push_back(rr);
    @(negedge clk);
    #1;
  endtask

  task automatic mon_cycle(input string tag, input exp_t e, input logic [1:0] g,
                           input logic [7:0] oe, input logic [7:0] o,
                           input logic rv, input logic to);
    check({tag, " gnt"},      {30'd0, g},  {30'd0, e.gnt});
    check({tag, " uio_oe"},   {24'd0, oe}, {24'd0, e.oe});
    check({tag, " uio_out"},  {24'd0, o},  {24'd0, e.out});
    check({tag, " rd_valid"}, {31'd0, rv}, {31'd0, e.rd_valid});
    check({tag, " timeout"},  {31'd0, to}, {31'd0, e.timeout});
    check({tag, " gnt_onehot"}, {31'd0, (g == 2'b11)}, 32'd0);
    check({tag, " oe_uniform"}, {31'd0, (oe != 8'h00 && oe != 8'hFF)}, 32'd0);
  endtask

  // Monitor A: per-cycle outputs, plus captured reads matched in order.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        exp_t e;
        e = exp_a.pop_front();
        mon_cycle("A", e, gnt_a, uio_oe_a, uio_out_a, rd_valid_a, timeout_a);
      end
      if (rd_valid_a === 1'b1) begin
        if (rdq_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL A rd_unexpected: got id %0d data %0h expected no read at %0t",
                   rd_id_a, rd_data_a, $time);
        end else begin
          rd_t r;
          r = rdq_a.pop_front();
          check("A rd_id",   {31'd0, rd_id_a},   {31'd0, r.id});
          check("A rd_data", {24'd0, rd_data_a}, {24'd0, r.data});
        end
      end
    end
  end

  // Monitor B: same checks for the long-turnaround, short-hold instance.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_b.size() > 0) begin
        exp_t e;
        e = exp_b.pop_front();
        mon_cycle("B", e, gnt_b, uio_oe_b, uio_out_b, rd_valid_b, timeout_b);
      end
      if (rd_valid_b === 1'b1) begin
        if (rdq_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL B rd_unexpected: got id %0d data %0h expected no read at %0t",
                   rd_id_b, rd_data_b, $time);
        end else begin
          rd_t r;
          r = rdq_b.pop_front();
          check("B rd_id",   {31'd0, rd_id_b},   {31'd0, r.id});
          check("B rd_data", {24'd0, rd_data_b}, {24'd0, r.data});
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    logic [1:0] rq_r, dr_r;
    ma = '{default: 0};
    mb = '{default: 0};
    rq_r = 2'b00; dr_r = 2'b00;

    repeat (3) cyc(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // Requester 0 drives A5 for three beats.
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 2'b01, 2'b01, (i == 4) ? 2'b01 : 2'b00, 8'hA5, 8'h00, 8'h00);
    repeat (3) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // Simultaneous requests from reset, two beats each.
    cyc(1, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 2'b11, 2'b11, (i == 3) ? 2'b01 : 2'b00, 8'h3C, 8'hC3, 8'h00);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 2'b10, 2'b11, (i == 2) ? 2'b10 : 2'b00, 8'h3C, 8'hC3, 8'h00);
    repeat (2) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 2'b11, 2'b11, (i % 3 == 2) ? 2'b11 : 2'b00, 8'h11, 8'h22, 8'h00);
    repeat (4) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // Requester 1 samples stepping pad data.
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 2'b10, 2'b00, (i == 4) ? 2'b10 : 2'b00, 8'h00, 8'h77,
          (i < 2) ? 8'h0F : 8'(8'h10 + i - 2));
    repeat (4) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // Requester 0 never signals last: forced release.
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 2'b01, 2'b01, 2'b00, 8'h5A, 8'h00, 8'h00);
    repeat (4) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // Reset in the middle of a drive tenure, then a fresh request.
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 2'b01, 2'b01, 2'b00, 8'h81, 8'h00, 8'h00);
    cyc(1, 1, 2'b01, 2'b01, 2'b00, 8'h81, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++)
      cyc(0, 1, 2'b01, 2'b01, (i == 6) ? 2'b01 : 2'b00, 8'h99, 8'h00, 8'h00);
    repeat (4) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // ena low blocks the grant; raising it starts the tenure.
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 2'b01, 2'b01, 2'b00, 8'h42, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++)
      cyc(0, 1, 2'b01, 2'b01, (i == 6) ? 2'b01 : 2'b00, 8'h42, 8'h00, 8'h00);
    // Back-to-back drive tenures exercise the turnaround gap.
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 2'b11, 2'b11, (i % 4 == 3) ? 2'b11 : 2'b00, 8'hE1, 8'h1E, 8'h00);
    repeat (5) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       r, en;
      logic [1:0] ls;
      if ($urandom_range(3) == 0) rq_r[0] = ~rq_r[0];
      if ($urandom_range(3) == 0) rq_r[1] = ~rq_r[1];
      if ($urandom_range(7) == 0) dr_r = 2'($urandom);
      ls = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      en = ($urandom_range(15) != 0);
      r  = ($urandom_range(299) == 0);
      cyc(r, en, rq_r, dr_r, ls, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (6) cyc(0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    check("A rd_leftover", 32'(rdq_a.size()), 32'd0);
    check("B rd_leftover", 32'(rdq_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
